// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: ALU results write directly, LSU results queue in a FIFO.
// Optional stall counter enabled by defining REGWB_STALL_COUNT_EN.
module regwb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [5:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [5:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        we3,
   output logic [5:0]  a3,
   output logic [31:0] wd3,
   output logic        lsu_pending
`ifdef REGWB_STALL_COUNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [37:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic [37:0]   head;

   // Ready and pop both look at the registered count, so a push into an
   // empty FIFO cannot pop on the same edge and a pop never frees a slot early.
   assign lsu_ready   = (count < DEPTH_C);
   assign lsu_pending = (count != '0);
   assign push        = lsu_valid & lsu_ready;
   assign pop         = ~alu_valid & (count != '0);
   assign head        = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {lsu_rd, lsu_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Results targeting register 0 still claim the port but never assert we3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3 <= 1'b0;
         a3  <= '0;
         wd3 <= '0;
      end else if (alu_valid) begin
         we3 <= (alu_rd != '0);
         a3  <= alu_rd;
         wd3 <= alu_data;
      end else if (pop) begin
         we3 <= (head[37:32] != '0);
         a3  <= head[37:32];
         wd3 <= head[31:0];
      end else begin
         we3 <= 1'b0;
      end
   end

`ifdef REGWB_STALL_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (lsu_valid && !lsu_ready) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Bench for regwb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regwb_arbiter;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [5:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [5:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        we3;
   logic [5:0]  a3;
   logic [31:0] wd3;
   logic        lsu_pending;
`ifdef REGWB_STALL_COUNT_EN
   logic [31:0] stall_cnt;
`endif

   regwb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .we3(we3), .a3(a3), .wd3(wd3), .lsu_pending(lsu_pending)
`ifdef REGWB_STALL_COUNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: accepted LSU results in acceptance order.
   logic [37:0] q[$];
   logic        exp_we;
   logic [5:0]  exp_a3;
   logic [31:0] exp_wd3;
   logic [31:0] exp_stall;
   logic        pre_ready_dut, pre_ready_exp, accepted;

   function automatic void model_reset();
      q.delete();
      exp_we    = 1'b0;
      exp_a3    = '0;
      exp_wd3   = '0;
      exp_stall = '0;
   endfunction

   // Called at posedge+1; drives one cycle of inputs, advances one edge, updates the model.
   task automatic tick(input logic av, input logic [5:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [5:0] lr, input logic [31:0] ld);
      logic        sel;
      logic [37:0] e;
      logic        rdy;
      alu_valid = av; alu_rd = ar; alu_data = ad;
      lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
      #1;
      pre_ready_dut = lsu_ready;
      rdy           = (q.size() < DEPTH);
      pre_ready_exp = rdy;
      sel = 1'b0;
      e   = '0;
      if (av) begin
         sel = 1'b1;
         e   = {ar, ad};
      end else if (q.size() > 0) begin
         sel = 1'b1;
         e   = q.pop_front();
      end
      if (lv && rdy) q.push_back({lr, ld});
      if (lv && !rdy) exp_stall = exp_stall + 32'd1;
      accepted = lv && rdy;
      exp_we = sel && (e[37:32] != 6'd0);
      if (sel) begin
         exp_a3  = e[37:32];
         exp_wd3 = e[31:0];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      model_reset();
      #12;
      total++;
      if ({we3, a3, wd3, lsu_pending} !== 40'd0) begin
         bad++;
         $display("FAIL reset_outputs: got we3=%b a3=%0d wd3=%h pend=%b, want all 0", we3, a3, wd3, lsu_pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (lsu_ready !== 1'b1 || we3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got ready=%b we3=%b, want ready=1 we3=0", lsu_ready, we3);
      end
   endtask

   task automatic test_alu_only();
      tick(1'b1, 6'd5, 32'h0000_00AA, 1'b0, 6'd0, 32'd0);
      total++;
      if (we3 !== 1'b1 || a3 !== 6'd5 || wd3 !== 32'h0000_00AA) begin
         bad++;
         $display("FAIL alu_only: got we3=%b a3=%0d wd3=%h, want 1 5 000000aa", we3, a3, wd3);
      end
      idle();
      total++;
      if (we3 !== 1'b0 || a3 !== 6'd5 || wd3 !== 32'h0000_00AA) begin
         bad++;
         $display("FAIL alu_idle_hold: got we3=%b a3=%0d wd3=%h, want 0 5 000000aa", we3, a3, wd3);
      end
   endtask

   task automatic test_collision();
      tick(1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22);
      total++;
      if (we3 !== 1'b1 || a3 !== 6'd3 || wd3 !== 32'h11 || lsu_pending !== 1'b1) begin
         bad++;
         $display("FAIL collision_alu: got we3=%b a3=%0d wd3=%h pend=%b, want 1 3 11 1", we3, a3, wd3, lsu_pending);
      end
      idle();
      total++;
      if (we3 !== 1'b1 || a3 !== 6'd4 || wd3 !== 32'h22 || lsu_pending !== 1'b0) begin
         bad++;
         $display("FAIL collision_lsu: got we3=%b a3=%0d wd3=%h pend=%b, want 1 4 22 0", we3, a3, wd3, lsu_pending);
      end
      idle();
      total++;
      if (we3 !== 1'b0) begin
         bad++;
         $display("FAIL collision_done: got we3=%b, want 0", we3);
      end
   endtask

   task automatic test_fill();
      logic [4:0] ready_seen;
      int         k;
      bit         offering;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 6'(10 + i), 32'(i), 1'b1, 6'(i + 1), 32'h100 + 32'(i));
         ready_seen[i] = pre_ready_dut;
      end
      total++;
      if (ready_seen !== 5'b01111) begin
         bad++;
         $display("FAIL fill_ready: got %b, want 01111", ready_seen);
      end
      total++;
      if (lsu_ready !== 1'b0 || lsu_pending !== 1'b1) begin
         bad++;
         $display("FAIL fill_full: got ready=%b pend=%b, want 0 1", lsu_ready, lsu_pending);
      end
      offering = 1'b1;
      for (k = 1; k <= 5; k++) begin
         tick(1'b0, 6'd0, 32'd0, offering, 6'd5, 32'h104);
         if (accepted) offering = 1'b0;
         total++;
         if (we3 !== 1'b1 || a3 !== 6'(k) || wd3 !== 32'h100 + 32'(k - 1)) begin
            bad++;
            $display("FAIL fill_drain_%0d: got we3=%b a3=%0d wd3=%h, want 1 %0d %h",
                     k, we3, a3, wd3, k, 32'h100 + 32'(k - 1));
         end
      end
      total++;
      if (offering !== 1'b0 || lsu_pending !== 1'b0) begin
         bad++;
         $display("FAIL fill_rd5: got still_offering=%b pend=%b, want 0 0", offering, lsu_pending);
      end
   endtask

   task automatic test_x0();
      tick(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 32'hDEAD_BEEF);
      total++;
      if (pre_ready_dut !== 1'b1 || lsu_pending !== 1'b1 || we3 !== 1'b0) begin
         bad++;
         $display("FAIL x0_accept: got ready=%b pend=%b we3=%b, want 1 1 0", pre_ready_dut, lsu_pending, we3);
      end
      idle();
      total++;
      if (lsu_pending !== 1'b0 || we3 !== 1'b0) begin
         bad++;
         $display("FAIL x0_pop: got pend=%b we3=%b, want 0 0", lsu_pending, we3);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 9) < 4), 6'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 9) < 6), 6'($urandom_range(0, 7)), $urandom);
         total++;
         if (pre_ready_dut !== pre_ready_exp || we3 !== exp_we ||
             lsu_pending !== (q.size() != 0) ||
             (exp_we && (a3 !== exp_a3 || wd3 !== exp_wd3))) begin
            bad++;
            errs++;
            if (errs <= 5)
               $display("FAIL random_%0d: got rdy=%b we3=%b a3=%0d wd3=%h pend=%b, want rdy=%b we3=%b a3=%0d wd3=%h pend=%b",
                        i, pre_ready_dut, we3, a3, wd3, lsu_pending,
                        pre_ready_exp, exp_we, exp_a3, exp_wd3, (q.size() != 0));
         end
      end
`ifdef REGWB_STALL_COUNT_EN
      total++;
      if (stall_cnt !== exp_stall) begin
         bad++;
         $display("FAIL random_stall: got %0d, want %0d", stall_cnt, exp_stall);
      end
`endif
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++)
         tick(1'b1, 6'd20, 32'h55, 1'b1, 6'(30 + i), 32'h300 + 32'(i));
      alu_valid = 1'b1; alu_rd = 6'd21; alu_data = 32'h66;
      lsu_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (we3 !== 1'b0 || lsu_pending !== 1'b0 || a3 !== 6'd0 || wd3 !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_async: got we3=%b pend=%b a3=%0d wd3=%h, want 0 0 0 0", we3, lsu_pending, a3, wd3);
      end
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (we3 !== 1'b0 || lsu_ready !== 1'b1 || lsu_pending !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_release: got we3=%b ready=%b pend=%b, want 0 1 0", we3, lsu_ready, lsu_pending);
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         total++;
         if (we3 !== 1'b0 || lsu_pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_stale_%0d: got we3=%b a3=%0d pend=%b, want we3=0 pend=0", i, we3, a3, lsu_pending);
         end
      end
   endtask

`ifdef REGWB_STALL_COUNT_EN
   task automatic test_stall_count();
      logic [31:0] base;
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         tick(1'b1, 6'd9, 32'd0, 1'b1, 6'd1, 32'd0);
      base = stall_cnt;
      for (int i = 0; i < 7; i++)
         tick(1'b1, 6'd9, 32'd0, 1'b1, 6'd1, 32'd0);
      total++;
      if (stall_cnt - base !== 32'd7 || stall_cnt !== 32'd7) begin
         bad++;
         $display("FAIL stall_count: got %0d (base %0d), want 7", stall_cnt, base);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu_only();
      test_collision();
      test_fill();
      test_x0();
      test_random();
      test_reset_mid();
`ifdef REGWB_STALL_COUNT_EN
      test_stall_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, want finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
